// File: rtl/iir_cascade_tdm.sv
// Cascade of direct-form-I biquads sharing one multiplier.
// Each section takes five MAC cycles plus one writeback cycle.
module iir_cascade_tdm #(
  parameter  int DATA_W  = 16,
  parameter  int COEF_W  = 16,
  parameter  int FRAC    = 14,
  parameter  int MAX_SEC = 4,
  localparam int OW      = $clog2(MAX_SEC + 1),
  localparam int AW      = $clog2(5 * MAX_SEC)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [OW-1:0]            order,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     clear_state,
  output logic                     busy,
  output logic                     sat_flag
);

  localparam int ACC_W = DATA_W + COEF_W + 4;
  localparam int PW    = DATA_W + COEF_W;
  localparam int NC    = 5 * MAX_SEC;
  localparam int SW    = (MAX_SEC > 1) ? $clog2(MAX_SEC) : 1;

  localparam logic signed [ACC_W-1:0] HALF =
    ACC_W'(64'sd1 <<< (FRAC - 1));
  localparam logic signed [ACC_W-1:0] YMAX =
    ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WB,
    OUT
  } state_t;

  state_t state, state_nx;

  logic signed [COEF_W-1:0] coef [NC];
  logic signed [DATA_W-1:0] x1 [MAX_SEC];
  logic signed [DATA_W-1:0] x2 [MAX_SEC];
  logic signed [DATA_W-1:0] y1 [MAX_SEC];
  logic signed [DATA_W-1:0] y2 [MAX_SEC];

  logic signed [DATA_W-1:0] x_cur;
  logic signed [ACC_W-1:0]  acc;
  logic [SW-1:0]            sec;
  logic [SW-1:0]            last;
  logic [2:0]               k;

  logic                     hs;
  logic                     clr;
  logic                     wr;
  logic [OW-1:0]            ord_c;
  logic [AW-1:0]            cidx;
  logic signed [COEF_W-1:0] op_c;
  logic signed [DATA_W-1:0] op_d;
  logic                     neg;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_x;
  logic signed [ACC_W-1:0]  rnd;
  logic signed [ACC_W-1:0]  shf;
  logic signed [DATA_W-1:0] y;
  logic                     sat_now;

  assign in_ready  = (state == IDLE) && !reset && !clear_state;
  assign hs        = in_valid && in_ready;
  assign clr       = (state == IDLE) && clear_state && !reset;
  assign wr        = coef_we && (state == IDLE) &&
                     (coef_addr < AW'(NC));
  assign ord_c     = (order > OW'(MAX_SEC)) ? OW'(MAX_SEC) : order;
  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);

  assign cidx = AW'(5 * int'(sec)) + AW'(k);

  always_comb begin
    op_c = coef[cidx];
    op_d = x_cur;
    neg  = 1'b0;
    unique case (k)
      3'd1: op_d = x1[sec];
      3'd2: op_d = x2[sec];
      3'd3: begin
        op_d = y1[sec];
        neg  = 1'b1;
      end
      3'd4: begin
        op_d = y2[sec];
        neg  = 1'b1;
      end
      default: op_d = x_cur;
    endcase
  end

  assign prod   = op_c * op_d;
  assign prod_x = {{(ACC_W - PW){prod[PW-1]}}, prod};

  // round half up, then clamp to the sample range
  assign rnd = acc + HALF;
  assign shf = rnd >>> FRAC;

  always_comb begin
    sat_now = 1'b0;
    y       = shf[DATA_W-1:0];
    if (shf > YMAX) begin
      sat_now = 1'b1;
      y       = YMAX[DATA_W-1:0];
    end else if (shf < YMIN) begin
      sat_now = 1'b1;
      y       = YMIN[DATA_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (hs) state_nx = (ord_c == '0) ? OUT : MAC;
      MAC:  if (k == 3'd4) state_nx = WB;
      WB:   state_nx = (sec == last) ? OUT : MAC;
      OUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NC; i++) coef[i] <= '0;
      for (int i = 0; i < MAX_SEC; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
      x_cur    <= '0;
      acc      <= '0;
      sec      <= '0;
      last     <= '0;
      k        <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (wr) coef[coef_addr] <= coef_data;
      if (clr) begin
        for (int i = 0; i < MAX_SEC; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end
      unique case (state)
        IDLE: begin
          if (hs) begin
            x_cur <= in_data;
            acc   <= '0;
            k     <= '0;
            sec   <= '0;
            last  <= SW'(ord_c - 1'b1);
            if (ord_c == '0) out_data <= in_data;
          end
        end
        MAC: begin
          acc <= neg ? (acc - prod_x) : (acc + prod_x);
          k   <= k + 3'd1;
        end
        WB: begin
          x1[sec] <= x_cur;
          x2[sec] <= x1[sec];
          y1[sec] <= y;
          y2[sec] <= y1[sec];
          x_cur   <= y;
          acc     <= '0;
          k       <= '0;
          if (sat_now) sat_flag <= 1'b1;
          if (sec == last) out_data <= y;
          else             sec      <= sec + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_cascade_tdm.sv
// Scoreboard bench for iir_cascade_tdm.
// A reference model predicts each output at input handshake.
module tb_iir_cascade_tdm;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int MS = 4;
  localparam int OW = 3;
  localparam int AW = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic [OW-1:0]        order;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 clear_state;
  logic                 busy;
  logic                 sat_flag;

  iir_cascade_tdm dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .order      (order),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .clear_state(clear_state),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int data;
    int lat;
    int hs;
  } exp_t;
  exp_t sb[$];

  int     mc [5*MS];
  longint mx1 [MS];
  longint mx2 [MS];
  longint my1 [MS];
  longint my2 [MS];
  bit     msat;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear_lines();
    for (int s = 0; s < MS; s++) begin
      mx1[s] = 0;
      mx2[s] = 0;
      my1[s] = 0;
      my2[s] = 0;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5*MS; i++) mc[i] = 0;
    model_clear_lines();
    msat = 1'b0;
  endtask

  task automatic model_run(input int x, input int ord, output int y);
    int     n;
    longint cur;
    longint a;
    longint v;
    n   = (ord > MS) ? MS : ord;
    cur = x;
    for (int s = 0; s < n; s++) begin
      a = longint'(mc[5*s]) * cur
        + longint'(mc[5*s+1]) * mx1[s]
        + longint'(mc[5*s+2]) * mx2[s]
        - longint'(mc[5*s+3]) * my1[s]
        - longint'(mc[5*s+4]) * my2[s];
      v = (a + 8192) >>> 14;
      if (v > 32767) begin
        v    = 32767;
        msat = 1'b1;
      end else if (v < -32768) begin
        v    = -32768;
        msat = 1'b1;
      end
      mx2[s] = mx1[s];
      mx1[s] = cur;
      my2[s] = my1[s];
      my1[s] = v;
      cur    = v;
    end
    y = int'(cur);
  endtask

  // entered and left just after a rising edge
  task automatic wcoef(input int a, input int d, input bit upd);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
    if (upd && a < 5*MS) mc[a] = d;
  endtask

  task automatic send(input int x, input int ord, input bit we = 1'b0,
                      input int wa = 0, input int wd = 0);
    bit   got;
    int   y;
    int   n;
    exp_t e;
    got       = 1'b0;
    in_valid  = 1'b1;
    in_data   = DW'(x);
    order     = OW'(ord);
    coef_we   = we;
    coef_addr = AW'(wa);
    coef_data = CW'(wd);
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      if (we && wa < 5*MS) mc[wa] = wd;
      model_run(x, ord, y);
      n      = (ord > MS) ? MS : ord;
      e.data = y;
      e.lat  = (n == 0) ? 1 : 6*n + 1;
      e.hs   = cyc;
      sb.push_back(e);
    end else begin
      chk("hs_timeout", 0, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 400; t++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain", sb.size(), 0);
  endtask

  logic ov_q = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid && !ov_q && sb.size() > 0)
        chk("latency", cyc - sb[0].hs, sb[0].lat);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          chk("out_data", out_data, sb[0].data);
          if (!out_ready) chk("hold_in_ready", in_ready, 0);
          else            void'(sb.pop_front());
        end
      end
    end
    ov_q <= out_valid;
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    order       = '0;
    out_ready   = 1'b1;
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_data   = '0;
    clear_state = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // unity gain section
    wcoef(0, 16384, 1'b1);
    send(100, 1);
    send(-200, 1);
    send(32767, 1);
    drain();

    // single-pole recursion, impulse response halves
    wcoef(3, -8192, 1'b1);
    send(1000, 1);
    for (int i = 0; i < 4; i++) send(0, 1);
    drain();
    chk("sat_clear", sat_flag, msat);

    // clear_state wins over a same-cycle handshake
    clear_state = 1'b1;
    in_valid    = 1'b1;
    in_data     = DW'(777);
    order       = OW'(1);
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("clr_busy", busy, 0);
    clear_state = 1'b0;
    in_valid    = 1'b0;
    model_clear_lines();
    send(0, 1);
    drain();

    // saturation is sticky
    wcoef(3, 0, 1'b1);
    wcoef(0, 32767, 1'b1);
    send(32767, 1);
    send(100, 1);
    drain();
    chk("sat_sticky", sat_flag, msat);

    // bypass under backpressure
    out_ready = 1'b0;
    send(-1234, 0);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // two-section cascade, then clamped order
    wcoef(0, 8192, 1'b1);
    wcoef(5, 8192, 1'b1);
    send(4000, 2);
    drain();
    wcoef(10, 16384, 1'b1);
    wcoef(15, 16384, 1'b1);
    send(4000, 7);
    drain();

    // writes while busy or out of range are dropped
    send(500, 1);
    wcoef(0, 4660, 1'b0);
    drain();
    wcoef(20, 16384, 1'b0);
    send(500, 1);
    drain();

    // write and handshake in the same cycle
    send(800, 1, 1'b1, 0, 16384);
    drain();

    // reset during section 1 MAC
    send(1000, 2);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    model_reset();
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sat", sat_flag, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rel_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(1000, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got 1 exp 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iir_cascade_tdm.md
IIR_CASCADE_TDM -- requirements
Module: iir_cascade_tdm

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, sample width, signed; COEF_W, 16, coefficient width, signed; FRAC, 14, coefficient fraction bits; MAX_SEC, 4, maximum biquad sections.
REQ-002 Ports SHALL be: clk  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous, active-high.
REQ-004 in_valid  in  1  input sample offered.
REQ-005 in_ready  out  1  input sample can be accepted.
REQ-006 in_data  in  DATA_W  signed input sample.
REQ-007 order  in  clog2(MAX_SEC+1)  active section count, sampled at input handshake.
REQ-008 out_valid  out  1  result available.
REQ-009 out_ready  in  1  downstream accepts result.
REQ-010 out_data  out  DATA_W  signed filtered sample.
REQ-011 coef_we  in  1  coefficient write strobe.
REQ-012 coef_addr  in  clog2(5*MAX_SEC)  coefficient index, section s at 5s+{0:b0,1:b1,2:b2,3:a1,4:a2}.
REQ-013 coef_data  in  COEF_W  signed coefficient.
REQ-014 clear_state  in  1  zero all section delay lines.
REQ-015 busy  out  1  high whenever the FSM is not in IDLE.
REQ-016 sat_flag  out  1  sticky: any section output saturated.

Function
REQ-017 Each section SHALL compute direct form I: acc = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2, with x1/x2 the section's past inputs and y1/y2 its past outputs.
REQ-018 acc SHALL be DATA_W+COEF_W+4 bits signed; y = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift (round half up), then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-019 Saturation of any section output SHALL set sat_flag; only reset clears it.
REQ-020 Section s output SHALL feed section s+1 input; section order-1 output SHALL be out_data.
REQ-021 One multiplier SHALL be time-shared; each section SHALL take 5 MAC cycles (one product per cycle) plus 1 writeback cycle that updates x1<=x, x2<=x1, y1<=y, y2<=y1.
REQ-022 The FSM SHALL have states IDLE, MAC, WB, OUT. IDLE->MAC on handshake when order>0; MAC->WB after the 5th product; WB->MAC for the next section, else WB->OUT; OUT->IDLE on out_valid&&out_ready.
REQ-023 in_ready SHALL be 1 only in IDLE; handshake = in_valid&&in_ready.
REQ-024 order=0 SHALL bypass the filter: IDLE->OUT with out_data=in_data, out_valid 1 cycle after handshake; delay lines unchanged.
REQ-025 order>MAX_SEC SHALL be clamped to MAX_SEC.
REQ-026 For order=N>0, out_valid SHALL rise exactly 6N+1 cycles after the handshake cycle.
REQ-027 out_valid and out_data SHALL hold stable in OUT until out_ready; no new input is accepted meanwhile.
REQ-028 A handshake-to-handshake throughput SHALL be one sample per 6N+2 cycles with out_ready tied high.
REQ-029 coef_we SHALL write only in IDLE; writes in other states SHALL be dropped; addresses >= 5*MAX_SEC SHALL be ignored.
REQ-030 clear_state SHALL act only in IDLE and SHALL have priority over a same-cycle input handshake (the handshake is not taken; in_ready deasserts that cycle); coefficients are unaffected.
REQ-031 Simultaneous coef_we and handshake in IDLE: the write SHALL complete and the sample SHALL use the new coefficient.

Reset
REQ-032 reset SHALL, at any state including mid-computation, return the FSM to IDLE and clear all delay lines, all coefficients, accumulator, sat_flag, out_data, out_valid and busy to 0; in_ready SHALL be 0 while reset is high and 1 the first cycle after.

Verification
REQ-033 Passthrough: order=1, b0=0x4000, rest 0, inputs 100,-200,32767 -> outputs 100,-200,32767, out_valid 7 cycles after each handshake.
REQ-034 Recursion: order=1, b0=0x4000, a1=0xE000 (-0.5), impulse 1000 then zeros -> 1000,500,250,125,63.
REQ-035 Saturation: order=1, b0=0x7FFF, input 32767 -> out_data 32767, sat_flag=1 and stays 1 on later in-range samples.
REQ-036 Backpressure/bypass: order=0, out_ready=0 for 5 cycles -> out_data=in_data held stable, in_ready=0 until out_ready=1 handshake.
REQ-037 Cascade: order=2, both sections b0=0x2000 (0.5), input 4000 -> output 1000 after 13 cycles; order=7 with MAX_SEC=4 -> latency 25.
REQ-038 Reset mid-operation: reset asserted in MAC of section 1 -> next cycle busy=0, out_valid=0, in_ready=1 after release, all coefficients read back as zero effect (impulse -> output 0).
